cpu_sequencer: RTL and testbench
================================

# cpu_sequencer

Multi-cycle control unit for the 8-bit, four-register CPU. It fetches instructions over a req/ack memory port, decodes them, and drives the register-file and ALU controls of the existing datapath one phase at a time. It owns the program counter, instruction register and zero flag, and it stops in a halt state on `HLT`. It sits between instruction memory and the datapath that produces `reg1`..`reg4`.

## Interface
- `PC_W`, default 8: program counter and memory address width.
- `clk`  in  1  single system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clk`.
- `mem_req`  out  1  fetch request; held high until acknowledged.
- `mem_addr`  out  PC_W  fetch address; equals `pc` while `mem_req` is high.
- `mem_ack`  in  1  data valid on `mem_rdata` this cycle; ignored when `mem_req` is low.
- `mem_rdata`  in  8  fetched byte.
- `rf_ra`, `rf_rb`  out  2 each  register-file read selects (rd, rs).
- `rf_we`  out  1  register write strobe, one cycle per write.
- `rf_wa`  out  2  write select.
- `wb_sel`  out  1  0 = ALU result, 1 = immediate/rs pass-through (`wb_data` path).
- `imm`  out  8  immediate operand latched from the second instruction byte.
- `alu_op`  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 PASS_B.
- `alu_zero`  in  1  datapath ALU result == 0, combinational from current operands.
- `pc`  out  PC_W  current program counter.
- `halted`  out  1  high in HALT state.

## Operation
- Instruction byte: [7:4] opcode, [3:2] rd, [1:0] rs. Opcodes: 0 NOP, 1 LDI rd,#imm8, 2 MOV rd,rs, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR (all rd <= rd op rs), 8 JMP #imm8, 9 JZ #imm8, F HLT. Opcodes A–E execute as NOP.
- States: FETCH, DECODE, FETCH_IMM, EXEC, HALT.
- FETCH: `mem_req`=1, `mem_addr`=pc. On `mem_ack`: ir<=mem_rdata, pc<=pc+1 (wraps 0xFF->0x00), go to DECODE. Without ack, stay in FETCH and hold the address.
- DECODE: opcode 1/8/9 -> FETCH_IMM; F -> HALT; 0 or A–E -> FETCH; else -> EXEC.
- FETCH_IMM: same handshake as FETCH. On ack: imm<=mem_rdata, pc<=pc+1. LDI -> EXEC. JMP -> pc<=mem_rdata (overrides increment) -> FETCH. JZ -> pc<=mem_rdata if zero flag = 1, else pc+1 -> FETCH.
- EXEC: one cycle, `rf_we`=1, `rf_wa`=rd, `rf_ra`=rd, `rf_rb`=rs. LDI: wb_sel=1, alu_op=PASS_B using imm. MOV: wb_sel=1, alu_op=PASS_B. ALU ops: wb_sel=0. Zero flag <= `alu_zero` for opcodes 3–7 only. Next state FETCH.
- HALT: all strobes low, `halted`=1. Only `reset` leaves HALT.
- `rf_we` is high only in EXEC. `mem_req` is high only in FETCH/FETCH_IMM.

## Timing
- Reset (edge with `reset`=1): state=FETCH, pc=0, ir=0, imm=0, zero flag=0. After reset, `mem_req`=1, `mem_addr`=0, `rf_we`=0, `halted`=0, `alu_op`=000, `wb_sel`=0. Reset overrides any in-flight fetch. An ack arriving in the reset cycle is discarded.
- All outputs are Moore decodes of state/ir/imm registers. There are no combinational paths from `mem_ack`/`mem_rdata` to outputs.
- Cycle counts with zero-wait memory (ack in the first request cycle): ALU/MOV = 3, LDI = 4, JMP/JZ = 3, NOP = 2. Each memory wait cycle adds 1.
- JZ tests the flag value registered before the JZ fetch began.
- pc wraps silently. An immediate fetched at 0xFF takes its byte from 0x00 of the next wrap.

## Structure
- Shared package `cpu_pkg`: opcode constants, `alu_op` encodings, state enum, instruction field positions.
- One combinational sub-module `cpu_decode`: opcode -> {needs_imm, is_alu, is_jump, is_halt, alu_op, wb_sel}. The FSM and registers stay in `cpu_sequencer`.

## Test plan
- Reset, zero-wait ROM: 0x1_4/0x05 (LDI r1,#5), 0x14/0x03 (LDI r1,#3 via rd=1), HLT -> writes r1=5 then r1=3, `halted`=1, pc=5.
- ADD with zero result: LDI r0,#1; LDI r1,#0xFF; ADD r0,r1 -> `rf_we` in EXEC with alu_op=000, zero flag=1. JZ #0x20 then fetches 0x20.
- Wait states: `mem_ack` delayed 3 cycles per fetch -> `mem_req`/`mem_addr` stable throughout, ALU instruction takes 6 cycles, no extra `rf_we`.
- Wrap: JMP #0xFF, byte 0xFF = LDI -> immediate read from 0x00, pc=0x01 afterwards.
- Reset mid-FETCH_IMM and while HALT: pulse `reset` -> next cycle state FETCH, pc=0, `mem_req`=1, `halted`=0, no `rf_we`.
- Spurious `mem_ack` during DECODE/EXEC -> ignored, pc and ir unchanged.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcodes, ALU encodings, FSM states and instruction fields for the 8-bit CPU
package cpu_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDI = 4'h1;
    localparam logic [3:0] OP_MOV = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OPC_MSB = 7;
    localparam int OPC_LSB = 4;
    localparam int RD_MSB  = 3;
    localparam int RD_LSB  = 2;
    localparam int RS_MSB  = 1;
    localparam int RS_LSB  = 0;

    typedef enum logic [2:0] {
        ALU_ADD    = 3'b000,
        ALU_SUB    = 3'b001,
        ALU_AND    = 3'b010,
        ALU_OR     = 3'b011,
        ALU_XOR    = 3'b100,
        ALU_PASS_B = 3'b101
    } alu_op_e;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_FETCH_IMM,
        S_EXEC,
        S_HALT
    } state_e;

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational opcode decode into sequencer control attributes
module cpu_decode
    import cpu_pkg::*;
(
    input  logic [3:0] i_opcode,
    output logic       o_needs_imm,
    output logic       o_is_alu,
    output logic       o_is_jump,
    output logic       o_is_halt,
    output logic [2:0] o_alu_op,
    output logic       o_wb_sel
);

    // Undefined opcodes fall through the defaults and behave as NOP.
    always_comb begin
        o_needs_imm = 1'b0;
        o_is_alu    = 1'b0;
        o_is_jump   = 1'b0;
        o_is_halt   = 1'b0;
        o_alu_op    = ALU_ADD;
        o_wb_sel    = 1'b0;
        case (i_opcode)
            OP_LDI: begin
                o_needs_imm = 1'b1;
                o_alu_op    = ALU_PASS_B;
                o_wb_sel    = 1'b1;
            end
            OP_MOV: begin
                o_alu_op = ALU_PASS_B;
                o_wb_sel = 1'b1;
            end
            OP_ADD: begin o_is_alu = 1'b1; o_alu_op = ALU_ADD; end
            OP_SUB: begin o_is_alu = 1'b1; o_alu_op = ALU_SUB; end
            OP_AND: begin o_is_alu = 1'b1; o_alu_op = ALU_AND; end
            OP_OR:  begin o_is_alu = 1'b1; o_alu_op = ALU_OR;  end
            OP_XOR: begin o_is_alu = 1'b1; o_alu_op = ALU_XOR; end
            OP_JMP, OP_JZ: begin
                o_needs_imm = 1'b1;
                o_is_jump   = 1'b1;
            end
            OP_HLT: o_is_halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute control unit owning pc, ir and zero flag
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    output logic            mem_req,
    output logic [PC_W-1:0] mem_addr,
    input  logic            mem_ack,
    input  logic [7:0]      mem_rdata,
    output logic [1:0]      rf_ra,
    output logic [1:0]      rf_rb,
    output logic            rf_we,
    output logic [1:0]      rf_wa,
    output logic            wb_sel,
    output logic [7:0]      imm,
    output logic [2:0]      alu_op,
    input  logic            alu_zero,
    output logic [PC_W-1:0] pc,
    output logic            halted
);

    state_e          r_state;
    logic [PC_W-1:0] r_pc;
    logic [7:0]      r_ir;
    logic [7:0]      r_imm;
    logic            r_zero;

    logic       w_needs_imm;
    logic       w_is_alu;
    logic       w_is_jump;
    logic       w_is_halt;
    logic [2:0] w_alu_op;
    logic       w_wb_sel;
    logic       w_exec;
    logic       w_take_jump;

    cpu_decode u_decode (
        .i_opcode    (r_ir[OPC_MSB:OPC_LSB]),
        .o_needs_imm (w_needs_imm),
        .o_is_alu    (w_is_alu),
        .o_is_jump   (w_is_jump),
        .o_is_halt   (w_is_halt),
        .o_alu_op    (w_alu_op),
        .o_wb_sel    (w_wb_sel)
    );

    // JZ looks at the flag as it stood before this instruction was fetched.
    assign w_take_jump = (r_ir[OPC_MSB:OPC_LSB] == OP_JMP) || r_zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
            r_pc    <= '0;
            r_ir    <= '0;
            r_imm   <= '0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ack) begin
                        r_ir    <= mem_rdata;
                        r_pc    <= r_pc + PC_W'(1);
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (w_needs_imm)
                        r_state <= S_FETCH_IMM;
                    else if (w_is_halt)
                        r_state <= S_HALT;
                    else if (w_is_alu || w_wb_sel)
                        r_state <= S_EXEC;
                    else
                        r_state <= S_FETCH;
                end
                S_FETCH_IMM: begin
                    if (mem_ack) begin
                        r_imm <= mem_rdata;
                        if (w_is_jump) begin
                            r_pc    <= w_take_jump ? PC_W'(mem_rdata) : r_pc + PC_W'(1);
                            r_state <= S_FETCH;
                        end else begin
                            r_pc    <= r_pc + PC_W'(1);
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    if (w_is_alu)
                        r_zero <= alu_zero;
                    r_state <= S_FETCH;
                end
                S_HALT:  r_state <= S_HALT;
                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign w_exec   = (r_state == S_EXEC);
    assign mem_req  = (r_state == S_FETCH) || (r_state == S_FETCH_IMM);
    assign mem_addr = r_pc;
    assign rf_we    = w_exec;
    assign rf_wa    = r_ir[RD_MSB:RD_LSB];
    assign rf_ra    = r_ir[RD_MSB:RD_LSB];
    assign rf_rb    = r_ir[RS_MSB:RS_LSB];
    assign wb_sel   = w_exec & w_wb_sel;
    assign alu_op   = w_exec ? w_alu_op : ALU_ADD;
    assign imm      = r_imm;
    assign pc       = r_pc;
    assign halted   = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - self-checking bench for cpu_sequencer with ROM responder and datapath model
module tb_cpu_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       mem_req;
    logic [7:0] mem_addr;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic [1:0] rf_ra;
    logic [1:0] rf_rb;
    logic       rf_we;
    logic [1:0] rf_wa;
    logic       wb_sel;
    logic [7:0] imm;
    logic [2:0] alu_op;
    logic       alu_zero;
    logic [7:0] pc;
    logic       halted;

    always #5 clk = ~clk;

    cpu_sequencer #(.PC_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .rf_ra     (rf_ra),
        .rf_rb     (rf_rb),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .wb_sel    (wb_sel),
        .imm       (imm),
        .alu_op    (alu_op),
        .alu_zero  (alu_zero),
        .pc        (pc),
        .halted    (halted)
    );

    typedef struct packed {
        logic [1:0] wa;
        logic [1:0] rb;
        logic [2:0] aop;
        logic       wsel;
        logic       ldi;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        int         prog;
        int         dly;
        bit         spur;
        int         abort_at;
        logic [7:0] exp_pc;
        int         exp_cyc;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[7];
    logic [7:0] rom[256];
    logic [7:0] m_regs[4];
    int         total = 0;
    int         bad = 0;

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a ^ b;
            default: return b;
        endcase
    endfunction

    always_comb alu_zero = (alu(m_regs[rf_ra], m_regs[rf_rb], alu_op) == 8'h00);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_prog(input int id);
        for (int i = 0; i < 256; i++) rom[i] = 8'hF0;
        case (id)
            0: begin
                rom[0] = 8'h14; rom[1] = 8'h05; rom[2] = 8'h14; rom[3] = 8'h03; rom[4] = 8'hF0;
            end
            1: begin
                rom[0] = 8'h10; rom[1] = 8'h01; rom[2] = 8'h14; rom[3] = 8'hFF;
                rom[4] = 8'h31; rom[5] = 8'h90; rom[6] = 8'h20; rom[7] = 8'h00;
            end
            2: begin
                rom[0]  = 8'h18; rom[1]  = 8'h0F; rom[2]  = 8'h1C; rom[3]  = 8'hF0;
                rom[4]  = 8'h26; rom[5]  = 8'h57; rom[6]  = 8'h67; rom[7]  = 8'h7B;
                rom[8]  = 8'h4A; rom[9]  = 8'h00; rom[10] = 8'hA5; rom[11] = 8'h90;
                rom[12] = 8'h40; rom[13] = 8'h00;
            end
            default: begin
                rom[0] = 8'h80; rom[1] = 8'hFF; rom[255] = 8'h14;
            end
        endcase
    endtask

    // Instruction-level reference: produces the expected register-write stream.
    task automatic run_model();
        logic [7:0] p;
        logic [7:0] op;
        logic [7:0] b;
        logic [7:0] r[4];
        logic [2:0] aop;
        logic [3:0] opc;
        bit         z;
        bit         done;
        wr_t        w;
        p = 8'h00; z = 1'b0; done = 1'b0;
        for (int k = 0; k < 4; k++) r[k] = 8'h00;
        exp_q.delete();
        for (int n = 0; n < 500 && !done; n++) begin
            op = rom[p]; p = p + 8'd1; opc = op[7:4];
            w = '0; w.wa = op[3:2]; w.rb = op[1:0];
            if (opc == 4'h1) begin
                b = rom[p]; p = p + 8'd1;
                w.aop = 3'd5; w.wsel = 1'b1; w.ldi = 1'b1; w.data = b;
                r[op[3:2]] = b; exp_q.push_back(w);
            end else if (opc == 4'h2) begin
                w.aop = 3'd5; w.wsel = 1'b1; w.data = r[op[1:0]];
                r[op[3:2]] = r[op[1:0]]; exp_q.push_back(w);
            end else if (opc >= 4'h3 && opc <= 4'h7) begin
                aop = 3'(opc - 4'd3);
                b = alu(r[op[3:2]], r[op[1:0]], aop);
                z = (b == 8'h00); r[op[3:2]] = b;
                w.aop = aop; w.data = b; exp_q.push_back(w);
            end else if (opc == 4'h8) begin
                p = rom[p];
            end else if (opc == 4'h9) begin
                p = z ? rom[p] : p + 8'd1;
            end else if (opc == 4'hF) begin
                done = 1'b1;
            end
        end
    endtask

    // Reset with an ack on the bus; the ack must be discarded.
    task automatic do_reset();
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h14;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", {mem_req, rf_we, halted, wb_sel, alu_op, mem_addr, pc, imm},
            {1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 8'h00, 8'h00, 8'h00});
    endtask

    task automatic run_vec(input vec_t v);
        int         cyc;
        int         wcnt;
        logic       prev_req;
        logic       prev_ack;
        logic [7:0] prev_pc;
        logic [7:0] prev_addr;
        wr_t        e;
        wr_t        pw;
        bit         pend;
        load_prog(v.prog);
        run_model();
        for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
        do_reset();
        cyc = 0; wcnt = 0; pend = 1'b0; pw = '0;
        prev_req = 1'b1; prev_ack = 1'b1; prev_pc = 8'h00; prev_addr = 8'h00;
        while (cyc < 2000) begin
            if (pend) begin
                m_regs[pw.wa] = pw.data;
                pend = 1'b0;
            end
            if (halted) break;
            if (v.abort_at >= 0 && cyc == v.abort_at) break;
            if (mem_req) chk("addr_is_pc", mem_addr, pc);
            if (cyc > 0 && prev_req && !prev_ack && mem_req) chk("addr_hold", mem_addr, prev_addr);
            if (cyc > 0 && !prev_req) chk("pc_hold", pc, prev_pc);
            if (rf_we) begin
                if (exp_q.size() == 0) begin
                    chk("extra_rf_we", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("write_ctl", {rf_wa, rf_ra, rf_rb, alu_op, wb_sel}, {e.wa, e.wa, e.rb, e.aop, e.wsel});
                    if (e.ldi) chk("write_imm", imm, e.data);
                    pw = e; pend = 1'b1;
                end
            end
            prev_req = mem_req; prev_addr = mem_addr; prev_pc = pc;
            if (mem_req) begin
                if (wcnt == v.dly) begin
                    mem_ack = 1'b1; mem_rdata = rom[mem_addr]; wcnt = 0;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 8'($urandom); wcnt++;
                end
            end else begin
                mem_ack = v.spur; mem_rdata = 8'($urandom); wcnt = 0;
            end
            prev_ack = mem_ack;
            @(negedge clk);
            cyc++;
        end
        if (v.abort_at < 0) begin
            chk("cycles", cyc, v.exp_cyc);
            chk("final_pc", pc, v.exp_pc);
            chk("halted", halted, 1);
            chk("writes_left", exp_q.size(), 0);
            for (int k = 0; k < 3; k++) begin
                mem_ack = 1'b1; mem_rdata = 8'h14;
                @(negedge clk);
                chk("halt_hold", {mem_req, rf_we, halted, pc}, {1'b0, 1'b0, 1'b1, v.exp_pc});
            end
        end else begin
            chk("abort_in_fetch_imm", {mem_req, rf_we, halted, pc}, {1'b1, 1'b0, 1'b0, 8'h01});
            exp_q.delete();
        end
    endtask

    initial begin
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = 8'h00;
        for (int k = 0; k < 4; k++) m_regs[k] = 8'h00;
        vecs[0] = '{0, 0, 1'b0, -1, 8'h05, 10};
        vecs[1] = '{1, 0, 1'b0, -1, 8'h21, 16};
        vecs[2] = '{1, 3, 1'b1, -1, 8'h21, 40};
        vecs[3] = '{2, 1, 1'b1, -1, 8'h41, 46};
        vecs[4] = '{3, 0, 1'b0, -1, 8'h02, 9};
        vecs[5] = '{0, 3, 1'b0,  6, 8'h00, 0};
        vecs[6] = '{0, 2, 1'b1, -1, 8'h05, 20};
        @(negedge clk);
        for (int i = 0; i < 7; i++) run_vec(vecs[i]);
        do_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
